// File: rtl/vga_bounce_box.sv
// Pixel-colour stage: draws a bouncing solid box over a background colour.
// Box position steps once per frame and reflects off the visible-area edges.
module vga_bounce_box #(
  parameter int          HVALID  = 640,
  parameter int          VVALID  = 480,
  parameter int          BOX_W   = 32,
  parameter int          BOX_H   = 32,
  parameter int          STEP_X  = 2,
  parameter int          STEP_Y  = 1,
  parameter int          X0      = 0,
  parameter int          Y0      = 0,
  parameter logic [11:0] BOX_RGB = 12'hF00,
  parameter logic [11:0] BG_RGB  = 12'h00F
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       PIX_CE,
  input  logic [9:0] PIX_X,
  input  logic [9:0] PIX_Y,
  input  logic       PIX_ACTIVE,
  input  logic       FRAME_TICK,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B,
  output logic [9:0] BOX_X,
  output logic [9:0] BOX_Y,
  output logic [7:0] BOUNCE_CNT
);

  localparam logic [10:0] LX  = 11'(HVALID - BOX_W);
  localparam logic [10:0] LY  = 11'(VVALID - BOX_H);
  localparam logic [10:0] SX  = 11'(STEP_X);
  localparam logic [10:0] SY  = 11'(STEP_Y);
  localparam logic [10:0] BW  = 11'(BOX_W);
  localparam logic [10:0] BH  = 11'(BOX_H);
  localparam logic [9:0]  RX  = 10'(X0);
  localparam logic [9:0]  RY  = 10'(Y0);

  logic [9:0]  box_x_q, box_y_q;
  logic        dx_neg_q, dy_neg_q;
  logic [7:0]  cnt_q;
  logic [11:0] rgb_q;

  logic [10:0] px, py, bx, by;
  logic        in_box;
  logic [11:0] rgb_d;
  logic [10:0] x_nxt, y_nxt;
  logic        x_bnc, y_bnc;

  // 11-bit compares so box_x + BOX_W never wraps at 1023
  always_comb begin
    px     = {1'b0, PIX_X};
    py     = {1'b0, PIX_Y};
    bx     = {1'b0, box_x_q};
    by     = {1'b0, box_y_q};
    in_box = (px >= bx) && (px < bx + BW) &&
             (py >= by) && (py < by + BH);
    rgb_d  = 12'h000;
    unique case (1'b1)
      !PIX_ACTIVE:           rgb_d = 12'h000;
      PIX_ACTIVE && in_box:  rgb_d = BOX_RGB;
      PIX_ACTIVE && !in_box: rgb_d = BG_RGB;
      default:               rgb_d = 12'h000;
    endcase
  end

  always_comb begin
    x_nxt = bx;
    x_bnc = 1'b0;
    if (!dx_neg_q) begin
      if (bx + SX >= LX) begin
        x_nxt = LX;
        x_bnc = 1'b1;
      end else begin
        x_nxt = bx + SX;
      end
    end else if (bx <= SX) begin
      x_nxt = 11'd0;
      x_bnc = 1'b1;
    end else begin
      x_nxt = bx - SX;
    end
  end

  always_comb begin
    y_nxt = by;
    y_bnc = 1'b0;
    if (!dy_neg_q) begin
      if (by + SY >= LY) begin
        y_nxt = LY;
        y_bnc = 1'b1;
      end else begin
        y_nxt = by + SY;
      end
    end else if (by <= SY) begin
      y_nxt = 11'd0;
      y_bnc = 1'b1;
    end else begin
      y_nxt = by - SY;
    end
  end

  // pixel compare above uses the pre-update position on a tick edge
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      box_x_q  <= RX;
      box_y_q  <= RY;
      dx_neg_q <= 1'b0;
      dy_neg_q <= 1'b0;
      cnt_q    <= 8'd0;
      rgb_q    <= 12'h000;
    end else if (PIX_CE) begin
      rgb_q <= rgb_d;
      if (FRAME_TICK) begin
        box_x_q  <= x_nxt[9:0];
        box_y_q  <= y_nxt[9:0];
        dx_neg_q <= dx_neg_q ^ x_bnc;
        dy_neg_q <= dy_neg_q ^ y_bnc;
        if (x_bnc || y_bnc)
          cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign VGA_R      = rgb_q[11:8];
  assign VGA_G      = rgb_q[7:4];
  assign VGA_B      = rgb_q[3:0];
  assign BOX_X      = box_x_q;
  assign BOX_Y      = box_y_q;
  assign BOUNCE_CNT = cnt_q;

endmodule
